// File: rtl/control_sequencer.sv
// Micro-sequencer: fetches one instruction at a time, decodes it and drives
// one-hot datapath enables plus config fields. A shift instruction can repeat its EXEC phase.
module control_sequencer #(
  parameter int ARG_W = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ARG_W+3:0]   instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               flag,
  input  logic               resume,
  output logic               en_a,
  output logic               en_b,
  output logic               en_out,
  output logic               en_shift,
  output logic               en_acc,
  output logic               shift_sel,
  output logic [1:0]         shift_cfg,
  output logic               alu_sel,
  output logic [2:0]         alu_cfg,
  output logic [1:0]         phase,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both 1; instr_ready is high only in FETCH and never during reset.

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10,
    HALT   = 2'b11
  } phase_t;

  phase_t           state;
  logic [ARG_W+3:0] ir;
  logic [ARG_W-1:0] rep_cnt;
  logic             flag_q;
  logic [CNT_W-1:0] retired_q;
  logic [3:0]       opcode;
  logic [ARG_W-1:0] arg;

  assign opcode = ir[ARG_W+3:ARG_W];
  assign arg    = ir[ARG_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      ir        <= '0;
      rep_cnt   <= '0;
      flag_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          flag_q <= flag;
          if (opcode == 4'd15) begin
            state     <= HALT;
            retired_q <= retired_q + CNT_W'(1);
          end else begin
            state   <= EXEC;
            rep_cnt <= (opcode >= 4'd3 && opcode <= 4'd6) ? arg : '0;
          end
        end
        EXEC: begin
          if (rep_cnt == '0) begin
            state     <= FETCH;
            retired_q <= retired_q + CNT_W'(1);
          end else begin
            rep_cnt <= rep_cnt - ARG_W'(1);
          end
        end
        HALT: begin
          if (resume) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, forced low while reset is held.
  always_comb begin
    instr_ready = 1'b0;
    en_a        = 1'b0;
    en_b        = 1'b0;
    en_out      = 1'b0;
    en_shift    = 1'b0;
    en_acc      = 1'b0;
    shift_sel   = 1'b0;
    shift_cfg   = 2'b00;
    alu_sel     = 1'b0;
    alu_cfg     = 3'b000;
    if (!rst) begin
      instr_ready = (state == FETCH);
      if (state == DECODE || state == EXEC) begin
        case (opcode)
          4'd3:  shift_cfg = 2'b11;
          4'd4: begin
            shift_cfg = 2'b11;
            shift_sel = 1'b1;
          end
          4'd5:  shift_cfg = 2'b01;
          4'd6:  shift_cfg = 2'b10;
          4'd7:  alu_sel   = 1'b1;
          4'd9:  alu_cfg   = 3'd0;
          4'd10: alu_cfg   = 3'd1;
          4'd11: alu_cfg   = 3'd2;
          4'd12: alu_cfg   = 3'd3;
          4'd13: alu_cfg   = 3'd4;
          4'd14: alu_cfg   = 3'd5;
          default: ;
        endcase
      end
      if (state == EXEC) begin
        case (opcode)
          4'd0:                       en_a     = 1'b1;
          4'd1:                       en_b     = 1'b1;
          4'd2:                       en_out   = 1'b1;
          4'd3, 4'd4, 4'd5, 4'd6:     en_shift = 1'b1;
          4'd7, 4'd8:                 en_acc   = flag_q;
          4'd9, 4'd10, 4'd11, 4'd12,
          4'd13, 4'd14:               en_acc   = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign phase   = state;
  assign halted  = (state == HALT);
  assign retired = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, each opcode class, repeat,
// conditional accumulate, halt/resume, reset mid-repeat and counter wrap.
module tb_control_sequencer;

  localparam int ARG_W = 3;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [ARG_W+3:0] instr;
  logic             instr_valid;
  logic             instr_ready;
  logic             flag;
  logic             resume;
  logic             en_a, en_b, en_out, en_shift, en_acc;
  logic             shift_sel;
  logic [1:0]       shift_cfg;
  logic             alu_sel;
  logic [2:0]       alu_cfg;
  logic [1:0]       phase;
  logic             halted;
  logic [CNT_W-1:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_sequencer #(.ARG_W(ARG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flag(flag), .resume(resume),
    .en_a(en_a), .en_b(en_b), .en_out(en_out), .en_shift(en_shift), .en_acc(en_acc),
    .shift_sel(shift_sel), .shift_cfg(shift_cfg), .alu_sel(alu_sel), .alu_cfg(alu_cfg),
    .phase(phase), .halted(halted), .retired(retired)
  );

  logic [4:0] en;
  logic [6:0] cfg;
  assign en  = {en_a, en_b, en_out, en_shift, en_acc};
  assign cfg = {shift_sel, shift_cfg, alu_sel, alu_cfg};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction in FETCH; returns one step later, in DECODE.
  task automatic send(input logic [3:0] op, input logic [ARG_W-1:0] a);
    instr       = {op, a};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0; flag = 1'b0; resume = 1'b0;
    step();
    step();
    chk("rst_phase",   8'(phase), 8'd0);
    chk("rst_ready",   8'(instr_ready), 8'd0);
    chk("rst_en",      8'(en), 8'd0);
    chk("rst_retired", 8'(retired), 8'd0);
    chk("rst_halted",  8'(halted), 8'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 8'(instr_ready), 8'd1);

    // Load A
    send(4'd0, 3'd0);
    chk("lda_phase_dec", 8'(phase), 8'd1);
    chk("lda_en_dec",    8'(en), 8'd0);
    chk("lda_ready_dec", 8'(instr_ready), 8'd0);
    step();
    chk("lda_phase_exec", 8'(phase), 8'd2);
    chk("lda_en_exec",    8'(en), 8'b10000);
    step();
    chk("lda_phase_fetch", 8'(phase), 8'd0);
    chk("lda_en_fetch",    8'(en), 8'd0);
    chk("lda_retired",     8'(retired), 8'd1);

    // op5 repeated 4 times
    send(4'd5, 3'd3);
    chk("shr_cfg_dec", 8'(cfg), 8'b0010000);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("shr_en_exec",  8'(en), 8'b00010);
      chk("shr_cfg_exec", 8'(cfg), 8'b0010000);
      chk("shr_phase",    8'(phase), 8'd2);
    end
    step();
    chk("shr_phase_fetch", 8'(phase), 8'd0);
    chk("shr_cfg_fetch",   8'(cfg), 8'd0);
    chk("shr_retired",     8'(retired), 8'd2);

    // op8 with flag high at DECODE, dropped in EXEC
    send(4'd8, 3'd0);
    flag = 1'b1;
    step();
    flag = 1'b0;
    #1;
    chk("cnd1_en", 8'(en), 8'b00001);
    step();
    chk("cnd1_retired", 8'(retired), 8'd3);
    // op8 with flag low at DECODE; fourth retirement wraps the 2-bit counter
    send(4'd8, 3'd0);
    step();
    chk("cnd0_en",    8'(en), 8'd0);
    chk("cnd0_phase", 8'(phase), 8'd2);
    step();
    chk("cnd0_retired_wrap", 8'(retired), 8'd0);

    // ALU op12
    send(4'd12, 3'd0);
    chk("alu_cfg_dec", 8'(cfg), 8'b0000011);
    step();
    chk("alu_en_exec",  8'(en), 8'b00001);
    chk("alu_cfg_exec", 8'(cfg), 8'b0000011);
    step();
    chk("alu_retired", 8'(retired), 8'd1);

    // op4 single shift with shift_sel
    send(4'd4, 3'd0);
    chk("sh4_cfg_dec", 8'(cfg), 8'b1110000);
    step();
    chk("sh4_en_exec", 8'(en), 8'b00010);
    step();
    chk("sh4_phase_fetch", 8'(phase), 8'd0);
    chk("sh4_retired", 8'(retired), 8'd2);

    // op7 with flag low: alu_sel set, no accumulate
    send(4'd7, 3'd0);
    chk("op7_cfg_dec", 8'(cfg), 8'b0001000);
    step();
    chk("op7_en_exec", 8'(en), 8'd0);
    step();
    chk("op7_retired", 8'(retired), 8'd3);

    // Halt with instr_valid held high
    instr = {4'd15, 3'd0};
    instr_valid = 1'b1;
    step();
    step();
    chk("hlt_phase",   8'(phase), 8'd3);
    chk("hlt_halted",  8'(halted), 8'd1);
    chk("hlt_retired", 8'(retired), 8'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hlt_ready_held", 8'(instr_ready), 8'd0);
      chk("hlt_phase_held", 8'(phase), 8'd3);
      chk("hlt_en_held",    8'(en), 8'd0);
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("res_phase",  8'(phase), 8'd0);
    chk("res_ready",  8'(instr_ready), 8'd1);
    chk("res_halted", 8'(halted), 8'd0);

    // Reset in the middle of a repeated shift
    send(4'd3, 3'd7);
    step();
    chk("rmid_en_exec1", 8'(en), 8'b00010);
    step();
    chk("rmid_en_exec2", 8'(en), 8'b00010);
    rst = 1'b1; resume = 1'b1; instr_valid = 1'b1; instr = {4'd15, 3'd0};
    #1;
    chk("rmid_en_in_rst",    8'(en), 8'd0);
    chk("rmid_ready_in_rst", 8'(instr_ready), 8'd0);
    chk("rmid_cfg_in_rst",   8'(cfg), 8'd0);
    step();
    chk("rmid_phase",   8'(phase), 8'd0);
    chk("rmid_retired", 8'(retired), 8'd0);
    step();
    rst = 1'b0; resume = 1'b0; instr_valid = 1'b0;
    #1;
    chk("rmid_rel_ready", 8'(instr_ready), 8'd1);
    chk("rmid_rel_phase", 8'(phase), 8'd0);
    step();
    chk("rmid_idle_phase", 8'(phase), 8'd0);

    // op1 and op2 enables
    send(4'd1, 3'd0);
    step();
    chk("op1_en", 8'(en), 8'b01000);
    step();
    send(4'd2, 3'd0);
    step();
    chk("op2_en", 8'(en), 8'b00100);
    step();
    chk("final_retired", 8'(retired), 8'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter ARG_W, default 3: width of instruction argument field (shift repeat count).
REQ-002 SHALL have parameter CNT_W, default 8: width of retired-instruction counter.
REQ-003 SHALL have ports, clock and reset first: clk in 1 (sole clock, rising edge); rst in 1 (synchronous, active-high).
REQ-004 SHALL have instr in 4+ARG_W: [ARG_W+3:ARG_W] opcode, [ARG_W-1:0] arg.
REQ-005 SHALL have instr_valid in 1 (source offers instr) and instr_ready out 1 (sequencer accepts).
REQ-006 SHALL have flag in 1: condition flag from ALU.
REQ-007 SHALL have resume in 1: leave HALT.
REQ-008 SHALL have enable outputs, 1 bit each: en_a, en_b, en_out, en_shift, en_acc.
REQ-009 SHALL have config outputs: shift_sel 1, shift_cfg 2, alu_sel 1, alu_cfg 3.
REQ-010 SHALL have status outputs: phase 2 (00 FETCH, 01 DECODE, 10 EXEC, 11 HALT), halted 1, retired CNT_W.

Function
REQ-011 SHALL implement FSM FETCH -> DECODE -> EXEC -> FETCH, plus HALT.
REQ-012 FETCH: instr_ready=1; on instr_valid&instr_ready latch instr into IR, go DECODE; else stay.
REQ-013 instr_ready SHALL be 0 in every state except FETCH.
REQ-014 DECODE (1 cycle): sample flag into flag_q; opcode 15 -> HALT; otherwise -> EXEC, rep_cnt = arg for opcodes 3-6, 0 otherwise.
REQ-015 EXEC: rep_cnt==0 -> FETCH and retired increments by 1; else rep_cnt decrements, stay EXEC; EXEC lasts rep_cnt+1 cycles.
REQ-016 HALT: halted=1, all enables 0; resume=1 -> FETCH next cycle; retired increments on HALT entry.
REQ-017 retired SHALL wrap from 2^CNT_W-1 to 0.
REQ-018 Config outputs SHALL be decoded from IR during DECODE and EXEC, 0 in FETCH and HALT.
REQ-019 Enables SHALL be asserted only in EXEC, every EXEC cycle, per opcode:
 - 0 en_a; 1 en_b; 2 en_out; 3-6 en_shift;
 - 7, 8 en_acc only if flag_q=1;
 - 9-14 en_acc unconditionally;
 - 15 none.
REQ-020 shift_cfg SHALL be: op3 11, op4 11, op5 01, op6 10, else 00; shift_sel=1 only for op4.
REQ-021 alu_sel SHALL be 1 only for op7; alu_cfg = opcode-9 for ops 9-14, 000 otherwise.
REQ-022 flag changes after DECODE SHALL NOT affect en_acc of the current instruction.
REQ-023 instr/instr_valid changes outside FETCH SHALL be ignored; IR stable until next accepted instr.
REQ-024 At most one enable output SHALL be 1 in any cycle.

Reset
REQ-025 rst=1 at a clock edge SHALL force phase FETCH, IR=0, rep_cnt=0, flag_q=0, retired=0, halted=0, regardless of current state (incl. mid-EXEC repeat or HALT).
REQ-026 While rst=1 all enables, config outputs and instr_ready SHALL be 0; first cycle after release, phase=FETCH and instr_ready=1.
REQ-027 resume and instr_valid asserted during reset SHALL have no effect.

Verification
REQ-028 Load A: instr op0 with valid in FETCH -> DECODE next cycle, en_a=1 for exactly 1 EXEC cycle, back to FETCH, retired=1.
REQ-029 Repeated shift: op5 arg=3 -> shift_cfg=01 in DECODE+EXEC, en_shift high 4 consecutive cycles, then FETCH.
REQ-030 Conditional: op8 with flag=1 at DECODE, flag=0 in EXEC -> en_acc=1; op8 with flag=0 at DECODE -> en_acc=0, retired still increments.
REQ-031 ALU: op12 -> alu_cfg=011 in DECODE and EXEC, en_acc=1 one cycle, alu_sel=0.
REQ-032 Halt: op15 -> phase=11, halted=1, instr_ready=0 with instr_valid held 1 for 5 cycles; resume pulse -> FETCH, instr_ready=1 next cycle.
REQ-033 Reset mid-op: op3 arg=7, rst after 2 EXEC cycles -> en_shift=0 immediately at reset, retired=0, FETCH after release; CNT_W=2, 4 retirements -> retired wraps to 0.
